spe_omem_port: RTL and testbench
================================

# spe_omem_port

Router-side port for one spiking PE (SPE). It turns the SPE core's per-neuron results into store packets for output memory, and its previous-spike lookups into request packets. It also consumes output memory's response packets and end-of-timestep packets, and keeps a per-timestep result count. One instance sits between each SPE core and its router node.

## Interface
- SPE_IDX, 0: SPE index 0..4; store opcode = 2*SPE_IDX, request opcode = 2*SPE_IDX+1
- SPE_ADDR, 2: this SPE's router address; carried in request data, matched as response destination
- OMEM_ADDR, 11: router address of output memory
- NUM_OUTPUTS, 88: results per timestep (89 for SPE_IDX 0 in the 21x21 map)
- NUM_TS, 2: timesteps per layer
- TIMEOUT_CYCLES, 1024: response timeout; used only with OMEM_RSP_TIMEOUT_EN
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- res_valid / res_ready  in / out  1  result handshake from core
- res_potential  in  13  residual membrane potential
- res_spike  in  1  spike bit
- prv_req_valid / prv_req_ready  in / out  1  previous-spike lookup request
- prv_valid  out  1  one-cycle pulse: previous spike available
- prv_spike  out  1  previous spike value, held until next prv_valid
- tx_valid / tx_ready  out / in  1  packet to router
- tx_data  out  33  packet: [32:29] dest, [28:25] opcode, [24:0] data
- rx_valid  in  1  packet from router
- rx_ready  out  1  tied high; every packet is accepted
- rx_data  in  33  same packet format
- ts_done  out  1  one-cycle pulse on end-of-timestep packet
- cur_ts  out  2  current timestep, 1..NUM_TS
- layer_done  out  1  sticky; set after the last timestep completes
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, SEND_RES, SEND_REQ, WAIT_RSP, TS_WAIT.
- IDLE transitions:
  - prv_req_valid has priority over res_valid.
  - Request with cur_ts==1: no packet is sent. prv_spike=0 and prv_valid pulses next cycle.
  - Request with cur_ts>1: load the request packet, go to SEND_REQ.
  - Result: load the store packet, go to SEND_RES.
- Store packet: dest=OMEM_ADDR, opcode=2*SPE_IDX, data={11'b0, res_potential, res_spike}.
- Request packet: dest=OMEM_ADDR, opcode=2*SPE_IDX+1, data={SPE_ADDR zero-extended to 24 bits, 1'b0}.
- SEND_RES:
  - On tx handshake, increment res_cnt.
  - If res_cnt reaches NUM_OUTPUTS, go to TS_WAIT; otherwise go to IDLE.
- SEND_REQ: on tx handshake, go to WAIT_RSP.
- WAIT_RSP: on an rx packet with dest==SPE_ADDR and opcode!=15:
  - prv_spike = rx_data[0], prv_valid pulses.
  - Go to IDLE. The response opcode field is ignored.
- Opcode 15 (timestep done), accepted in any state:
  - ts_done pulses and res_cnt clears.
  - If cur_ts<NUM_TS, cur_ts increments and TS_WAIT goes to IDLE.
  - Otherwise layer_done is set and the FSM stays in TS_WAIT.
- err is set, and the packet dropped, on any of:
  - a response packet outside WAIT_RSP;
  - opcode 15 while res_cnt<NUM_OUTPUTS;
  - an rx packet with dest!=SPE_ADDR.
- res_ready is high only in IDLE with no prv_req_valid and layer_done==0.
- prv_req_ready is high only in IDLE with layer_done==0.
- Counter widths: res_cnt is $clog2(NUM_OUTPUTS+1) bits; it wraps only via the clear.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0, prv_valid=0, prv_spike=0;
  - ts_done=0, cur_ts=1, layer_done=0, err=0;
  - res_ready=0 and prv_req_ready=0 during reset; state=IDLE, res_cnt=0.
- Latency:
  - Result accepted at edge N gives tx_valid=1 from edge N+1.
  - tx_data is registered and stable while tx_valid=1 && tx_ready=0.
- Throughput: one result per 2 cycles when tx_ready is held high.
- Response rx in cycle N gives prv_valid=1 in cycle N+1.
- Opcode 15 arriving in the same cycle as a response is legal. Both are processed in that cycle.
- Reset mid-operation: an in-flight tx packet is dropped and any pending response is forgotten.

## Configuration
- OMEM_RSP_TIMEOUT_EN defined:
  - A WAIT_RSP cycle counter runs.
  - After TIMEOUT_CYCLES cycles without a response: err is set, prv_spike=0, prv_valid pulses, FSM returns to IDLE.
  - A late response then counts as a response outside WAIT_RSP (err, dropped).
- OMEM_RSP_TIMEOUT_EN undefined: WAIT_RSP waits indefinitely and no counter logic exists.

## Structure
- Package spe_omem_pkg holds:
  - packet field bounds (32/29, 28/25, 24/0) and the 33-bit packet typedef;
  - OP_TIMESTEP_DONE=15;
  - store/request opcode functions of SPE_IDX;
  - the FSM state enum.
- One sub-module, spe_omem_pkt_fmt: combinational packet builder for store and request packets. The FSM and counters stay in the top module.

## Test plan
- SPE_IDX=2, cur_ts=1, res_potential=100, res_spike=1 -> tx_data=33'h1_6800_00C9 one cycle after acceptance; held under 3 cycles of tx_ready=0.
- cur_ts=1 lookup request -> no tx activity; prv_valid next cycle with prv_spike=0.
- After advancing to cur_ts=2, lookup request -> tx_data=33'h1_6A00_0004. Then rx {dest 2, opcode 2, data 1} -> prv_spike=1, prv_valid one cycle later.
- 88 results, then opcode-15 packet -> res_ready low after result 88; ts_done pulse; cur_ts=2; res_cnt=0. Second round ending with opcode 15 -> layer_done=1, res_ready stays 0.
- Opcode 15 after only 10 results -> err=1, cur_ts unchanged. Stray response in IDLE -> err=1, no prv_valid.
- rst asserted while SEND_REQ is stalled -> tx_valid=0 immediately, cur_ts=1, err=0. With OMEM_RSP_TIMEOUT_EN and TIMEOUT_CYCLES=16, no response -> err=1 and prv_valid 16 cycles after the request handshake.

Source files
------------

// File: rtl/spe_omem_pkg.sv
// rtl/spe_omem_pkg.sv - packet layout, opcodes and FSM states shared by spe_omem_port
package spe_omem_pkg;
    localparam int PKT_W   = 33;
    localparam int DEST_HI = 32;
    localparam int DEST_LO = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 25;
    localparam int DATA_HI = 24;
    localparam int DATA_LO = 0;

    typedef logic [PKT_W-1:0] pkt_t;

    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

    function automatic logic [3:0] store_opcode(input int spe_idx);
        return 4'(2 * spe_idx);
    endfunction

    function automatic logic [3:0] req_opcode(input int spe_idx);
        return 4'(2 * spe_idx + 1);
    endfunction

    typedef enum logic [2:0] {IDLE, SEND_RES, SEND_REQ, WAIT_RSP, TS_WAIT} state_t;
endpackage

// File: rtl/spe_omem_pkt_fmt.sv
// rtl/spe_omem_pkt_fmt.sv - combinational builder for store and previous-spike request packets
module spe_omem_pkt_fmt
    import spe_omem_pkg::*;
#(
    parameter int SPE_IDX   = 0,
    parameter int SPE_ADDR  = 2,
    parameter int OMEM_ADDR = 11
) (
    input  logic [12:0] res_potential,
    input  logic        res_spike,
    output pkt_t        store_pkt,
    output pkt_t        req_pkt
);
    always_comb begin
        store_pkt = '0;
        store_pkt[DEST_HI:DEST_LO] = 4'(OMEM_ADDR);
        store_pkt[OP_HI:OP_LO]     = store_opcode(SPE_IDX);
        store_pkt[DATA_HI:DATA_LO] = {11'b0, res_potential, res_spike};

        // The requester's address rides in the data field so memory knows where to reply.
        req_pkt = '0;
        req_pkt[DEST_HI:DEST_LO] = 4'(OMEM_ADDR);
        req_pkt[OP_HI:OP_LO]     = req_opcode(SPE_IDX);
        req_pkt[DATA_HI:DATA_LO] = {24'(SPE_ADDR), 1'b0};
    end
endmodule

// File: rtl/spe_omem_port.sv
// rtl/spe_omem_port.sv - SPE router port: result stores, spike lookups, timestep tracking
// Optional response timeout: define OMEM_RSP_TIMEOUT_EN.
module spe_omem_port
    import spe_omem_pkg::*;
#(
    parameter int SPE_IDX        = 0,
    parameter int SPE_ADDR       = 2,
    parameter int OMEM_ADDR      = 11,
    parameter int NUM_OUTPUTS    = 88,
    parameter int NUM_TS         = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [12:0] res_potential,
    input  logic        res_spike,
    input  logic        prv_req_valid,
    output logic        prv_req_ready,
    output logic        prv_valid,
    output logic        prv_spike,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [32:0] tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [32:0] rx_data,
    output logic        ts_done,
    output logic [1:0]  cur_ts,
    output logic        layer_done,
    output logic        err
);
    localparam int CW = $clog2(NUM_OUTPUTS + 1);

    state_t        state;
    logic [CW-1:0] res_cnt;
    pkt_t          store_pkt;
    pkt_t          req_pkt;
    logic          rx_mine;
    logic          rx_ts;
    logic          rx_rsp;
    logic          unused_rx_bits;

    spe_omem_pkt_fmt #(
        .SPE_IDX  (SPE_IDX),
        .SPE_ADDR (SPE_ADDR),
        .OMEM_ADDR(OMEM_ADDR)
    ) u_fmt (
        .res_potential(res_potential),
        .res_spike    (res_spike),
        .store_pkt    (store_pkt),
        .req_pkt      (req_pkt)
    );

    assign rx_ready       = 1'b1;
    assign rx_mine        = rx_valid && (rx_data[DEST_HI:DEST_LO] == 4'(SPE_ADDR));
    assign rx_ts          = rx_mine && (rx_data[OP_HI:OP_LO] == OP_TIMESTEP_DONE);
    assign rx_rsp         = rx_mine && (rx_data[OP_HI:OP_LO] != OP_TIMESTEP_DONE);
    assign unused_rx_bits = ^rx_data[DATA_HI:1];

    assign prv_req_ready = !rst && (state == IDLE) && !layer_done;
    assign res_ready     = !rst && (state == IDLE) && !prv_req_valid && !layer_done;

`ifdef OMEM_RSP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            res_cnt    <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            prv_valid  <= 1'b0;
            prv_spike  <= 1'b0;
            ts_done    <= 1'b0;
            cur_ts     <= 2'd1;
            layer_done <= 1'b0;
            err        <= 1'b0;
`ifdef OMEM_RSP_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            prv_valid <= 1'b0;
            ts_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (prv_req_valid && !layer_done) begin
                        // First timestep has no history: answer locally with a zero spike.
                        if (cur_ts == 2'd1) begin
                            prv_spike <= 1'b0;
                            prv_valid <= 1'b1;
                        end else begin
                            tx_data  <= req_pkt;
                            tx_valid <= 1'b1;
                            state    <= SEND_REQ;
                        end
                    end else if (res_valid && !layer_done) begin
                        tx_data  <= store_pkt;
                        tx_valid <= 1'b1;
                        state    <= SEND_RES;
                    end
                end
                SEND_RES: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        res_cnt  <= res_cnt + CW'(1);
                        state    <= (res_cnt == CW'(NUM_OUTPUTS - 1)) ? TS_WAIT : IDLE;
                    end
                end
                SEND_REQ: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= WAIT_RSP;
`ifdef OMEM_RSP_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
`ifdef OMEM_RSP_TIMEOUT_EN
                WAIT_RSP: begin
                    if (!rx_rsp) begin
                        if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            err       <= 1'b1;
                            prv_spike <= 1'b0;
                            prv_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                end
`endif
                default: ;
            endcase

            if (rx_valid && !rx_mine) begin
                err <= 1'b1;
            end

            if (rx_rsp) begin
                if (state == WAIT_RSP) begin
                    prv_spike <= rx_data[0];
                    prv_valid <= 1'b1;
                    state     <= IDLE;
                end else begin
                    err <= 1'b1;
                end
            end

            if (rx_ts) begin
                if (res_cnt != CW'(NUM_OUTPUTS)) begin
                    err <= 1'b1;
                end else begin
                    ts_done <= 1'b1;
                    res_cnt <= '0;
                    if (cur_ts < 2'(NUM_TS)) begin
                        cur_ts <= cur_ts + 2'd1;
                        if (state == TS_WAIT) begin
                            state <= IDLE;
                        end
                    end else begin
                        layer_done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spe_omem_port.sv
// tb/tb_spe_omem_port.sv - self-checking bench for spe_omem_port
module tb_spe_omem_port;
    localparam int SPE_IDX        = 2;
    localparam int SPE_ADDR       = 2;
    localparam int OMEM_ADDR      = 11;
    localparam int NUM_OUTPUTS    = 88;
    localparam int NUM_TS         = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [12:0] res_potential = '0;
    logic        res_spike = 1'b0;
    logic        prv_req_valid = 1'b0;
    logic        prv_req_ready;
    logic        prv_valid;
    logic        prv_spike;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [32:0] tx_data;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [32:0] rx_data = '0;
    logic        ts_done;
    logic [1:0]  cur_ts;
    logic        layer_done;
    logic        err;

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    int model_ts = 1;
    int model_layer = 0;

    typedef struct {
        logic [12:0] pot;
        logic        spike;
        int          stall;
        logic [32:0] exp;
    } vec_t;

    spe_omem_port #(
        .SPE_IDX(SPE_IDX), .SPE_ADDR(SPE_ADDR), .OMEM_ADDR(OMEM_ADDR),
        .NUM_OUTPUTS(NUM_OUTPUTS), .NUM_TS(NUM_TS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_potential(res_potential), .res_spike(res_spike),
        .prv_req_valid(prv_req_valid), .prv_req_ready(prv_req_ready),
        .prv_valid(prv_valid), .prv_spike(prv_spike),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .ts_done(ts_done), .cur_ts(cur_ts), .layer_done(layer_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] mk_pkt(input longint dest, input longint op, input longint data);
        longint v;
        v = dest * (64'd1 << 29) + op * (64'd1 << 25) + data;
        return v[32:0];
    endfunction

    function automatic logic [32:0] exp_store(input int pot, input int sp);
        return mk_pkt(OMEM_ADDR, 2 * SPE_IDX, pot * 2 + sp);
    endfunction

    function automatic logic [32:0] exp_req();
        return mk_pkt(OMEM_ADDR, 2 * SPE_IDX + 1, SPE_ADDR * 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_result(input logic [12:0] pot, input logic sp, input logic [32:0] expd, input int stall);
        int w;
        w = 0;
        while (!res_ready && w < 50) begin
            tick();
            w++;
        end
        if (!res_ready) begin
            check("res_ready_wait", 0, 1);
            return;
        end
        res_valid = 1'b1;
        res_potential = pot;
        res_spike = sp;
        tick();
        res_valid = 1'b0;
        check("store_valid", tx_valid, 1);
        check("store_data", tx_data, expd);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("store_hold", {tx_valid, tx_data}, {1'b1, expd});
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("store_done", tx_valid, 0);
        model_cnt++;
    endtask

    task automatic fill(input int n);
        int pot;
        int sp;
        for (int i = 0; i < n; i++) begin
            pot = $urandom_range(0, 8191);
            sp = $urandom_range(0, 1);
            send_result(13'(pot), 1'(sp), exp_store(pot, sp), $urandom_range(0, 2));
        end
    endtask

    task automatic send_rx(input int dest, input int op, input int data);
        rx_data = mk_pkt(dest, op, data);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic end_timestep();
        int was_full;
        was_full = (model_cnt == NUM_OUTPUTS);
        send_rx(SPE_ADDR, 15, 0);
        check("ts_done_pulse", ts_done, was_full);
        if (was_full != 0) begin
            model_cnt = 0;
            if (model_ts < NUM_TS) model_ts++;
            else model_layer = 1;
        end
        check("cur_ts", cur_ts, model_ts);
        check("layer_done", layer_done, model_layer);
        check("err_after_ts", err, 0);
        tick();
        check("ts_done_clear", ts_done, 0);
        check("res_ready_after_ts", res_ready, model_layer == 0);
    endtask

    task automatic lookup_send(input int stall);
        check("prv_req_ready", prv_req_ready, 1);
        prv_req_valid = 1'b1;
        tick();
        prv_req_valid = 1'b0;
        check("req_valid", tx_valid, 1);
        check("req_data", tx_data, exp_req());
        for (int i = 0; i < stall; i++) begin
            tick();
            check("req_hold", {tx_valid, tx_data}, {1'b1, exp_req()});
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("req_done", tx_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_cnt = 0;
        model_ts = 1;
        model_layer = 0;
        check("reset_err", err, 0);
        check("reset_cur_ts", cur_ts, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int hs;
        int seen;
        int k;

        tbl[0] = '{13'd100,  1'b1, 3, 33'h1_6800_00C9};
        tbl[1] = '{13'd0,    1'b0, 0, 33'h1_6800_0000};
        tbl[2] = '{13'd8191, 1'b1, 1, 33'h1_6800_3FFF};
        tbl[3] = '{13'd4096, 1'b0, 2, 33'h1_6800_2000};

        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_prv", {prv_valid, prv_spike}, 0);
        check("rst_ts_done", ts_done, 0);
        check("rst_cur_ts", cur_ts, 1);
        check("rst_layer_err", {layer_done, err}, 0);
        check("rst_readies", {res_ready, prv_req_ready}, 0);
        rst = 1'b0;
        tick();
        check("idle_res_ready", res_ready, 1);
        check("rx_ready", rx_ready, 1);

        for (int i = 0; i < 4; i++)
            send_result(tbl[i].pot, tbl[i].spike, tbl[i].exp, tbl[i].stall);

        // First-timestep lookup is answered locally.
        check("ts1_req_ready", prv_req_ready, 1);
        prv_req_valid = 1'b1;
        tick();
        prv_req_valid = 1'b0;
        check("ts1_prv_valid", prv_valid, 1);
        check("ts1_prv_spike", prv_spike, 0);
        check("ts1_no_tx", tx_valid, 0);
        tick();
        check("ts1_prv_pulse", prv_valid, 0);

        // Back-to-back results with tx_ready held high.
        hs = 0;
        res_valid = 1'b1;
        res_potential = 13'd7;
        res_spike = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid) begin
                hs++;
                check("burst_data", tx_data, exp_store(7, 0));
            end
        end
        res_valid = 1'b0;
        tx_ready = 1'b0;
        check("burst_rate", hs, 10);
        model_cnt += hs;

        fill(NUM_OUTPUTS - model_cnt);
        check("full_res_ready", res_ready, 0);
        check("full_req_ready", prv_req_ready, 0);
        end_timestep();

        lookup_send(2);
        repeat (3) begin
            tick();
            check("wait_no_prv", prv_valid, 0);
        end
        send_rx(SPE_ADDR, 2, 1);
        check("rsp_prv_valid", prv_valid, 1);
        check("rsp_prv_spike", prv_spike, 1);
        tick();
        check("rsp_prv_pulse", prv_valid, 0);
        check("rsp_prv_hold", prv_spike, 1);

        fill(NUM_OUTPUTS);
        end_timestep();
        res_valid = 1'b1;
        repeat (3) begin
            tick();
            check("layer_res_ready", res_ready, 0);
            check("layer_no_tx", tx_valid, 0);
        end
        res_valid = 1'b0;

        do_reset();
        fill(10);
        send_rx(SPE_ADDR, 15, 0);
        check("early_ts_err", err, 1);
        check("early_ts_cur", cur_ts, 1);
        check("early_ts_pulse", ts_done, 0);

        do_reset();
        send_rx(SPE_ADDR, 2, 1);
        check("stray_rsp_err", err, 1);
        check("stray_rsp_prv", prv_valid, 0);

        do_reset();
        send_rx(5, 15, 0);
        check("bad_dest_err", err, 1);
        check("bad_dest_ts", ts_done, 0);

        do_reset();
        fill(NUM_OUTPUTS);
        end_timestep();
        lookup_send(0);
`ifdef OMEM_RSP_TIMEOUT_EN
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick();
            if (prv_valid) k = i;
        end
        check("timeout_latency", k, TIMEOUT_CYCLES);
        check("timeout_err", err, 1);
        check("timeout_spike", prv_spike, 0);
        send_rx(SPE_ADDR, 2, 1);
        check("late_rsp_dropped", prv_valid, 0);
        check("late_rsp_idle", res_ready, 1);
`else
        k = 0;
        seen = 0;
        repeat (20) begin
            tick();
            if (prv_valid) seen++;
        end
        check("no_timeout", seen, k);
        check("no_timeout_err", err, 0);
        send_rx(SPE_ADDR, 2, 0);
        check("slow_rsp_valid", prv_valid, 1);
        check("slow_rsp_spike", prv_spike, 0);
`endif

        // Asynchronous reset while a request is stalled on the router.
        prv_req_valid = 1'b1;
        tick();
        prv_req_valid = 1'b0;
        check("stall_req_valid", tx_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_cur_ts", cur_ts, 1);
        check("midrst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_tx", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
